pn_result_sorter: RTL and testbench
===================================

Name: pn_result_sorter

Overview:
- Sits directly downstream of the Polish Notation evaluator and consumes its stream of per-expression results (up to DEPTH signed values per frame).
- Buffers one frame and sorts it by signed value, ascending or descending, using a fixed-latency odd-even transposition network.
- Streams the sorted frame out, one word per cycle, with an end-of-frame marker.

Parameters:
- DEPTH, 4, maximum results per frame (even, >=2)
- WIDTH, 32, result word width (two's complement)
- CNT_W, 3, counter width; must hold 0..DEPTH

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset; asynchronous, active-high
- in_valid  input  1  in_data/in_last valid this cycle
- in_data  input  WIDTH  signed result word
- in_last  input  1  marks final word of the frame
- descend  input  1  sort order, sampled with the first word of a frame (0 = ascending, 1 = descending)
- in_ready  output  1  block accepts input this cycle
- out_valid  output  1  out_data valid
- out_data  output  WIDTH  sorted word
- out_last  output  1  final sorted word of the frame
- overflow  output  1  current/last frame had more than DEPTH words

Behaviour:
- Reset (rst_n=1, async): state IDLE; in_ready=1; out_valid=0, out_data=0, out_last=0, overflow=0; count=0; all buffer entries=0. Reset asserted mid-frame aborts immediately, no partial output.
- States: IDLE, LOAD, SORT, OUT.
- IDLE:
  - in_ready=1.
  - in_valid=1 -> entry0 <= in_data, order <= descend, count <= 1, overflow <= 0.
  - in_last=1 -> SORT, else -> LOAD.
- LOAD:
  - in_ready=1; in_valid=0 cycles (gaps) are allowed and change nothing.
  - Accepted word with count<DEPTH -> entry[count] <= in_data, count+1.
  - Accepted word with count==DEPTH -> word dropped, overflow <= 1 (sticky until next frame start), count saturates.
  - in_last on an accepted word -> SORT; that word obeys the same store/drop rule.
- SORT:
  - in_ready=0. Runs exactly DEPTH phase cycles; phase counter starts at 0.
  - Even phase compares pairs (0,1),(2,3)...; odd phase compares (1,2),(3,4)...
  - Pairs with any index >= count are untouched.
  - Comparison is signed WIDTH-bit. Swap when (order=0 and a>b) or (order=1 and a<b); equal values are not swapped.
  - After phase DEPTH-1 -> OUT, index=0.
- OUT:
  - in_ready=0; out_valid=1 for exactly count consecutive cycles, out_data = entry[index], index+1 per cycle.
  - out_last=1 only with the word at index count-1; next state IDLE.
  - No backpressure; the consumer must take every word.
- Latency: the first out_valid occurs exactly DEPTH+1 cycles after the edge that samples in_last, independent of count. Frame throughput: count+DEPTH+1 cycles after the last input word, plus one IDLE cycle.
- in_valid while in_ready=0 is ignored; no state change and no overflow.
- count==1: sort phases run with no compares; single word is output with out_last=1.
- out_data and out_last return to 0 whenever out_valid=0.
- overflow holds its value through OUT and IDLE and clears on the next frame's first accepted word.

Test Plan:
- Ascending, 4 words: descend=0, in {5,-3,12,0}, in_last on 4th -> out {-3,0,5,12}; out_valid 4 cycles starting DEPTH+1=5 cycles after last edge; out_last on 12; overflow=0.
- Descending with duplicates: descend=1, in {-1,7,-1,2} -> out {7,2,-1,-1}. Extreme values in {0x80000000,0x7FFFFFFF} ascending -> {0x80000000,0x7FFFFFFF} (signed compare).
- Single word and gaps: in {9} with in_last -> out {9}, out_last=1, still 5-cycle latency. Frame {3,1,2} with 2 idle cycles between words -> out {1,2,3}.
- Overflow: 6 words {4,3,2,1,8,9}, in_last on 6th -> out {1,2,3,4} only; overflow=1 held until next frame's first word, then 0.
- Busy ignore: drive in_valid=1 with data 100 throughout SORT and OUT -> no change to the sorted output; the next frame starts only after return to IDLE.
- Reset mid-SORT: assert rst_n=1 during phase 2 -> out_valid stays 0, in_ready=1 and all outputs at reset values the same cycle; a following frame {2,1} -> {1,2}.

Source files
------------

// File: rtl/pn_result_sorter_if.sv
// Stream interface between the Polish Notation evaluator, the result sorter and its consumer.
// The master side feeds results and receives sorted words; the slave side is the sorter.
interface pn_result_sorter_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             descend;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             overflow;

    modport master (
        output in_valid, in_data, in_last, descend,
        input  in_ready, out_valid, out_data, out_last, overflow
    );

    modport slave (
        input  in_valid, in_data, in_last, descend,
        output in_ready, out_valid, out_data, out_last, overflow
    );
endinterface

// File: rtl/pn_result_sorter.sv
// Buffers one frame of evaluator results, sorts it with a DEPTH-phase odd-even
// transposition network and streams the sorted frame out one word per cycle.
//
//   state  | meaning
//   IDLE   | waiting for the first word of a frame
//   LOAD   | collecting words until in_last (extra words dropped, overflow set)
//   SORT   | DEPTH compare/swap phases, even pairs then odd pairs
//   OUT    | streaming count sorted words, out_last on the final one
module pn_result_sorter #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    pn_result_sorter_if.slave res_if
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SORT = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] ptr_q, ptr_d;
    logic             order_q, order_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [WIDTH-1:0] entry_d [DEPTH];
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;

    function automatic logic needs_swap(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b,
                                        input logic             desc);
        return desc ? ($signed(a) < $signed(b)) : ($signed(a) > $signed(b));
    endfunction

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        ptr_d       = ptr_q;
        order_d     = order_q;
        ovf_d       = ovf_q;
        entry_d     = entry_q;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_last_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (res_if.in_valid) begin
                    entry_d[0] = res_if.in_data;
                    order_d    = res_if.descend;
                    count_d    = CNT_W'(1);
                    ovf_d      = 1'b0;
                    ptr_d      = '0;
                    state_d    = res_if.in_last ? S_SORT : S_LOAD;
                end
            end
            S_LOAD: begin
                if (res_if.in_valid) begin
                    if (count_q < CNT_W'(DEPTH)) begin
                        entry_d[count_q[IDX_W-1:0]] = res_if.in_data;
                        count_d = count_q + CNT_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (res_if.in_last) begin
                        ptr_d   = '0;
                        state_d = S_SORT;
                    end
                end
            end
            S_SORT: begin
                // Pairs within one phase are disjoint, so all swaps read the registered entries.
                for (int i = 0; i < DEPTH - 1; i++) begin
                    if (((i % 2) == int'(ptr_q[0])) && ((i + 1) < int'(count_q))) begin
                        if (needs_swap(entry_q[i], entry_q[i+1], order_q)) begin
                            entry_d[i]   = entry_q[i+1];
                            entry_d[i+1] = entry_q[i];
                        end
                    end
                end
                if (ptr_q == CNT_W'(DEPTH - 1)) begin
                    ptr_d   = '0;
                    state_d = S_OUT;
                end else begin
                    ptr_d = ptr_q + CNT_W'(1);
                end
            end
            S_OUT: begin
                out_valid_d = 1'b1;
                out_data_d  = entry_q[ptr_q[IDX_W-1:0]];
                ptr_d       = ptr_q + CNT_W'(1);
                if (ptr_q == count_q - CNT_W'(1)) begin
                    out_last_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            ptr_q       <= '0;
            order_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            ptr_q       <= ptr_d;
            order_q     <= order_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    assign res_if.in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign res_if.out_valid = out_valid_q;
    assign res_if.out_data  = out_data_q;
    assign res_if.out_last  = out_last_q;
    assign res_if.overflow  = ovf_q;
endmodule

// File: tb/tb_pn_result_sorter.sv
// Directed bench for pn_result_sorter: hand-sorted frames, latency/handshake timing,
// overflow stickiness, busy-input ignore and asynchronous reset during SORT.
module tb_pn_result_sorter;
    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
    localparam int CNT_W = 3;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   vin  [8];
    int   vexp [8];
    logic last_ovf;

    pn_result_sorter_if #(.WIDTH(WIDTH)) res_if ();

    pn_result_sorter #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .res_if(res_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drives n words of vin; returns just after the edge that samples in_last.
    task automatic send_frame(input int n, input logic desc, input int gap);
        for (int j = 0; j < n; j++) begin
            if (j > 0) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    res_if.in_valid = 1'b0;
                    @(posedge clk);
                end
            end
            @(negedge clk);
            chk("ovf_pre", res_if.overflow, (j == 0) ? last_ovf : logic'((j - 1) >= DEPTH));
            chk("rdy_load", res_if.in_ready, 1'b1);
            res_if.in_valid = 1'b1;
            res_if.in_data  = vin[j];
            res_if.in_last  = (j == n - 1);
            res_if.descend  = desc;
            @(posedge clk);
        end
        last_ovf = (n > DEPTH);
    endtask

    // Checks cycle-by-cycle from the in_last edge through the cycle after out_last.
    task automatic collect(input int n_in, input logic busy);
        int  nout;
        logic ovf;
        nout = (n_in > DEPTH) ? DEPTH : n_in;
        ovf  = (n_in > DEPTH);
        for (int k = 0; k <= DEPTH + 1 + nout; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            res_if.in_valid = busy && (k <= DEPTH - 1 + nout);
            res_if.in_data  = busy ? 32'd100 : 32'd0;
            res_if.in_last  = busy;
            chk("in_ready", res_if.in_ready, logic'(k > DEPTH - 1 + nout));
            chk("out_valid", res_if.out_valid, logic'((k >= DEPTH + 1) && (k <= DEPTH + nout)));
            if ((k >= DEPTH + 1) && (k <= DEPTH + nout)) begin
                chk("out_data", res_if.out_data, vexp[k-DEPTH-1]);
                chk("out_last", res_if.out_last, logic'(k == DEPTH + nout));
            end else begin
                chk("out_data_idle", res_if.out_data, 32'd0);
                chk("out_last_idle", res_if.out_last, 1'b0);
            end
            chk("overflow", res_if.overflow, ovf);
        end
        res_if.in_valid = 1'b0;
        res_if.in_last  = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_in_ready", res_if.in_ready, 1'b1);
        chk("rst_out_valid", res_if.out_valid, 1'b0);
        chk("rst_out_data", res_if.out_data, 32'd0);
        chk("rst_out_last", res_if.out_last, 1'b0);
        chk("rst_overflow", res_if.overflow, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        last_ovf = 1'b0;
        rst_n = 1'b1;
        res_if.in_valid = 1'b0;
        res_if.in_data  = '0;
        res_if.in_last  = 1'b0;
        res_if.descend  = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b0;

        // ascending, 4 words
        vin  = '{5, -3, 12, 0, 0, 0, 0, 0};
        vexp = '{-3, 0, 5, 12, 0, 0, 0, 0};
        send_frame(4, 1'b0, 0);
        collect(4, 1'b0);

        // descending with duplicates
        vin  = '{-1, 7, -1, 2, 0, 0, 0, 0};
        vexp = '{7, 2, -1, -1, 0, 0, 0, 0};
        send_frame(4, 1'b1, 0);
        collect(4, 1'b0);

        // signed extremes, ascending
        vin  = '{int'(32'h7FFF_FFFF), int'(32'h8000_0000), 0, 0, 0, 0, 0, 0};
        vexp = '{int'(32'h8000_0000), int'(32'h7FFF_FFFF), 0, 0, 0, 0, 0, 0};
        send_frame(2, 1'b0, 0);
        collect(2, 1'b0);

        // single word
        vin  = '{9, 0, 0, 0, 0, 0, 0, 0};
        vexp = '{9, 0, 0, 0, 0, 0, 0, 0};
        send_frame(1, 1'b1, 0);
        collect(1, 1'b0);

        // three words with two idle cycles between them
        vin  = '{3, 1, 2, 0, 0, 0, 0, 0};
        vexp = '{1, 2, 3, 0, 0, 0, 0, 0};
        send_frame(3, 1'b0, 2);
        collect(3, 1'b0);

        // overflow: last two words dropped
        vin  = '{4, 3, 2, 1, 8, 9, 0, 0};
        vexp = '{1, 2, 3, 4, 0, 0, 0, 0};
        send_frame(6, 1'b0, 0);
        collect(6, 1'b0);

        // busy ignore; also shows overflow held until this frame's first word
        vin  = '{10, -20, 30, -40, 0, 0, 0, 0};
        vexp = '{-40, -20, 10, 30, 0, 0, 0, 0};
        send_frame(4, 1'b0, 0);
        collect(4, 1'b1);

        // reset during sort phase 2
        vin = '{8, 6, 5, 7, 0, 0, 0, 0};
        send_frame(4, 1'b1, 0);
        @(negedge clk);
        res_if.in_valid = 1'b0;
        res_if.in_last  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_reset_outputs();
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_valid", res_if.out_valid, 1'b0);
        end
        rst_n = 1'b0;
        last_ovf = 1'b0;

        vin  = '{2, 1, 0, 0, 0, 0, 0, 0};
        vexp = '{1, 2, 0, 0, 0, 0, 0, 0};
        send_frame(2, 1'b0, 0);
        collect(2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
